// File: rtl/stencil_sweeper.sv
// stencil_sweeper: sequences one heat-diffusion time step over a ROWS x COLS
// grid of 5.27 fixed-point words.
//   clk, reset          : clock, synchronous active-high reset
//   start / busy / done : host handshake (start sampled in IDLE, done pulses once)
//   rd_addr / rd_data   : grid n read port, data returns one cycle after address
//   node_*              : stencil window to the external combinational update unit
//   new_center          : update unit result for the current window
//   wr_en/wr_addr/wr_data : grid n+1 write port, one cycle behind the window
module stencil_sweeper #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic [31:0]   node_center,
  output logic [31:0]   node_up,
  output logic [31:0]   node_down,
  output logic [31:0]   node_left,
  output logic [31:0]   node_right,
  input  logic [31:0]   new_center,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data
);
  localparam int CW = $clog2(COLS + 1);  // column counter reaches COLS in LOAD
  localparam int IW = $clog2(COLS);      // row buffer word index
  localparam int RW = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, FLUSH, DONE} state_t;

  state_t              state, nxt;
  logic [CW-1:0]       cnt;
  logic [RW-1:0]       erow;      // row being emitted
  logic [1:0]          sel_c;     // buffer holding the emitted row
  logic [1:0]          sel_ld;    // buffer being loaded
  logic                first_ld;  // row 0 load: a second load follows directly
  logic [AW-1:0]       base, last_rd, wcnt;
  logic [2:0][COLS-1:0][31:0] rbuf;

  logic rd_issue, load_end, emit_end, bnd;
  logic [1:0] sel_up, sel_dn;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign rd_issue = (state == LOAD) && (cnt != CW'(COLS));
  assign load_end = (state == LOAD) && (cnt == CW'(COLS));
  assign emit_end = (state == EMIT) && (cnt == CW'(COLS - 1));
  assign rd_addr  = rd_issue ? base + AW'(cnt) : last_rd;
  assign sel_up   = (sel_c == 2'd0) ? 2'd2 : sel_c - 2'd1;
  assign sel_dn   = (sel_c == 2'd2) ? 2'd0 : sel_c + 2'd1;
  assign bnd      = (erow == '0) || (erow == RW'(ROWS - 1)) ||
                    (cnt == '0) || (cnt == CW'(COLS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = LOAD;
      LOAD:  if (load_end) nxt = first_ld ? LOAD : EMIT;
      EMIT:  if (emit_end) begin
               if (erow == RW'(ROWS - 1))      nxt = FLUSH;
               else if (erow == RW'(ROWS - 2)) nxt = EMIT;  // last row already loaded
               else                            nxt = LOAD;
             end
      FLUSH: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Sequencing counters, read address hold and the single write stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; erow <= '0; sel_c <= '0; sel_ld <= '0; first_ld <= 1'b0;
      base <= '0; last_rd <= '0; wcnt <= '0;
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
    end else begin
      wr_en <= (state == EMIT);
      if (state == EMIT) begin
        wr_addr <= wcnt;
        wr_data <= bnd ? node_center : new_center;
        wcnt    <= wcnt + AW'(1);
      end
      if (rd_issue) last_rd <= rd_addr;
      case (state)
        IDLE: if (start) begin
          cnt <= '0; erow <= '0; sel_c <= '0; sel_ld <= '0;
          first_ld <= 1'b1; base <= '0; wcnt <= '0;
        end
        LOAD: if (load_end) begin
          cnt      <= '0;
          base     <= base + AW'(COLS);
          sel_ld   <= (sel_ld == 2'd2) ? 2'd0 : sel_ld + 2'd1;
          first_ld <= 1'b0;
        end else cnt <= cnt + CW'(1);
        EMIT: if (emit_end) begin
          cnt   <= '0;
          erow  <= erow + RW'(1);
          sel_c <= sel_dn;
        end else cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

  // Row buffers; capture lags the issued address by one cycle.
  always_ff @(posedge clk) begin
    if (state == LOAD && cnt != '0)
      rbuf[sel_ld][IW'(cnt - CW'(1))] <= rd_data;
  end

  // Stencil window; out-of-grid neighbours mirror the center word.
  logic [IW-1:0] ci, li, ri;
  always_comb begin
    ci = '0; li = '0; ri = '0;
    node_center = '0; node_up = '0; node_down = '0;
    node_left = '0; node_right = '0;
    if (state == EMIT) begin
      ci = IW'(cnt);
      li = (cnt == '0) ? ci : IW'(cnt - CW'(1));
      ri = (cnt == CW'(COLS - 1)) ? ci : IW'(cnt + CW'(1));
      node_center = rbuf[sel_c][ci];
      node_left   = rbuf[sel_c][li];
      node_right  = rbuf[sel_c][ri];
      node_up     = (erow == '0) ? rbuf[sel_c][ci] : rbuf[sel_up][ci];
      node_down   = (erow == RW'(ROWS - 1)) ? rbuf[sel_c][ci] : rbuf[sel_dn][ci];
    end
  end
endmodule

// File: tb/tb_stencil_sweeper.sv
// Bench for stencil_sweeper: three instances (4x4, 4x5, 8x8) with memory and
// update-unit models; results are compared against a grid-level reference.
module tb_stencil_sweeper;
  function automatic int rows(int g); return (g == 2) ? 8 : 4; endfunction
  function automatic int cols(int g); return (g == 0) ? 4 : ((g == 1) ? 5 : 8); endfunction

  // new = c + (u + d + l + r - 4c) / 8, two's complement wrap
  function automatic logic [31:0] upd(input logic [31:0] c, u, d, l, r);
    logic signed [34:0] sc, su, sd, sl, sr, s;
    sc = $signed(c); su = $signed(u); sd = $signed(d); sl = $signed(l); sr = $signed(r);
    s = su + sd + sl + sr - (sc <<< 2);
    return c + 32'(s >>> 3);
  endfunction

  logic clk, reset;
  logic start[3], busy[3], done[3], wr_en[3];
  logic [9:0] rd_addr[3], wr_addr[3];
  logic [31:0] wr_data[3], ncen[3], nup[3], ndn[3], nlf[3], nrt[3], newc[3];
  logic [31:0] mem[3][2][64];
  logic rsel[3];
  int cyc, n_chk, n_pass;
  int wexp[3], wcnt[3], wbad[3], rexp[3], rcnt[3], rbad[3], rprev[3];
  int dcnt[3], dcyc[3], bfirst[3], blast[3], s0[3];

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    logic [5:0]  ra_s;
    logic [31:0] rdd;
    always @(negedge clk) ra_s <= rd_addr[g][5:0];
    always @(posedge clk) rdd <= mem[g][rsel[g]][ra_s];
    assign newc[g] = upd(ncen[g], nup[g], ndn[g], nlf[g], nrt[g]);
    stencil_sweeper #(.COLS(cols(g)), .ROWS(rows(g)), .AW(10)) dut (
      .clk(clk), .reset(reset), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .rd_addr(rd_addr[g]), .rd_data(rdd),
      .node_center(ncen[g]), .node_up(nup[g]), .node_down(ndn[g]),
      .node_left(nlf[g]), .node_right(nrt[g]), .new_center(newc[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]));
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic arm(input int g);
    wexp[g] = 0; wcnt[g] = 0; wbad[g] = 0; rexp[g] = 0; rcnt[g] = 0; rbad[g] = 0;
    rprev[g] = -1; dcnt[g] = 0; dcyc[g] = -1; bfirst[g] = -1; blast[g] = -1;
  endtask

  // Advance one cycle and observe all instances mid-cycle.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (wr_en[g]) begin
        if (int'(wr_addr[g]) != wexp[g]) wbad[g]++;
        wexp[g]++; wcnt[g]++;
        mem[g][!rsel[g]][wr_addr[g][5:0]] = wr_data[g];
      end
      if (busy[g]) begin
        if (bfirst[g] < 0) bfirst[g] = cyc;
        blast[g] = cyc;
        if (int'(rd_addr[g]) != rprev[g]) begin
          if (int'(rd_addr[g]) != rexp[g]) rbad[g]++;
          rexp[g]++; rcnt[g]++; rprev[g] = int'(rd_addr[g]);
        end
      end
      if (done[g]) begin dcnt[g]++; dcyc[g] = cyc; end
    end
  endtask

  function automatic logic outs_any(input int g);
    return busy[g] | done[g] | wr_en[g] | (|rd_addr[g]) | (|wr_addr[g]) | (|wr_data[g]) |
           (|ncen[g]) | (|nup[g]) | (|ndn[g]) | (|nlf[g]) | (|nrt[g]);
  endfunction

  // mode 0: constant v, 1: word = index, 2: random
  task automatic fill(input int g, input int mode, input logic [31:0] v);
    for (int i = 0; i < 64; i++) begin
      mem[g][rsel[g]][i]  = (mode == 0) ? v : (mode == 1) ? 32'(i) : $urandom();
      mem[g][!rsel[g]][i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic sweep(input int g, input int p1, input int p2);
    arm(g); s0[g] = cyc; start[g] = 1; tick(); start[g] = 0;
    for (int k = 1; k < 3000; k++) begin
      if (k == p1 || k == p2) start[g] = 1;
      tick(); start[g] = 0;
      if (dcyc[g] >= 0 && cyc >= dcyc[g] + 4) break;
    end
  endtask

  task automatic check_sweep(input int g, input string tag);
    int R, C, D, bad, idx;
    logic [31:0] e;
    R = rows(g); C = cols(g); D = s0[g] + R * (2 * C + 1) + 2; bad = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        idx = r * C + c;
        if (r == 0 || r == R - 1 || c == 0 || c == C - 1) e = mem[g][rsel[g]][idx];
        else e = upd(mem[g][rsel[g]][idx], mem[g][rsel[g]][idx - C], mem[g][rsel[g]][idx + C],
                     mem[g][rsel[g]][idx - 1], mem[g][rsel[g]][idx + 1]);
        if (mem[g][!rsel[g]][idx] !== e) bad++;
      end
    chk({tag, "_grid_bad"}, bad, 0);
    chk({tag, "_done_cyc"}, dcyc[g], D);
    chk({tag, "_done_cnt"}, dcnt[g], 1);
    chk({tag, "_busy_first"}, bfirst[g], s0[g] + 1);
    chk({tag, "_busy_last"}, blast[g], D);
    chk({tag, "_wr_cnt"}, wcnt[g], R * C);
    chk({tag, "_wr_order"}, wbad[g], 0);
    chk({tag, "_rd_cnt"}, rcnt[g], R * C);
    chk({tag, "_rd_order"}, rbad[g], 0);
  endtask

  initial begin
    int d1;
    reset = 1;
    for (int g = 0; g < 3; g++) begin start[g] = 0; rsel[g] = 0; arm(g); fill(g, 0, 0); end
    repeat (3) tick();
    reset = 0; tick();
    for (int g = 0; g < 3; g++) chk("reset_state", outs_any(g), 0);

    // uniform 4x4
    fill(0, 0, 32'h0800_0000);
    sweep(0, 0, 0);
    check_sweep(0, "unif");
    chk("unif_w15", mem[0][1][15], 32'h0800_0000);
    chk("unif_w5", mem[0][1][5], 32'h0800_0000);

    // single hot point at (1,1)
    fill(0, 0, 0); mem[0][0][5] = 32'h0800_0000;
    sweep(0, 0, 0);
    check_sweep(0, "hot");
    chk("hot_a5", mem[0][1][5], 32'h0400_0000);
    chk("hot_a6", mem[0][1][6], 32'h0100_0000);
    chk("hot_a9", mem[0][1][9], 32'h0100_0000);
    chk("hot_a1", mem[0][1][1], 0);
    chk("hot_a4", mem[0][1][4], 0);
    chk("hot_a10", mem[0][1][10], 0);

    // 4x5 index grid: address order, boundary pass-through
    fill(1, 1, 0);
    sweep(1, 0, 0);
    check_sweep(1, "addr");
    chk("addr_w19", mem[1][1][19], 19);
    chk("addr_w5", mem[1][1][5], 5);
    chk("addr_w7", mem[1][1][7], 7);

    // start pulses mid-sweep are ignored
    fill(0, 2, 0);
    sweep(0, 5, 20);
    check_sweep(0, "ign");

    // start held high: relaunch right after returning to IDLE
    fill(0, 2, 0);
    arm(0); s0[0] = cyc; start[0] = 1;
    for (int k = 0; k < 200 && dcyc[0] < 0; k++) tick();
    d1 = dcyc[0];
    chk("held_done1", d1, s0[0] + 38);
    arm(0);
    tick(); tick();
    chk("held_relaunch", bfirst[0], d1 + 2);
    chk("held_rd0", rd_addr[0], 0);
    start[0] = 0;
    for (int k = 0; k < 200 && dcyc[0] < 0; k++) tick();
    repeat (3) tick();
    chk("held_done2", dcyc[0], d1 + 39);
    chk("held_wcnt", wcnt[0], 16);

    // reset mid-LOAD abandons the sweep
    arm(0); start[0] = 1; tick(); start[0] = 0; tick(); tick();
    reset = 1; tick();
    chk("rst_mid1", outs_any(0), 0);
    tick();
    chk("rst_mid2", outs_any(0), 0);
    reset = 0; arm(0);
    repeat (40) tick();
    chk("rst_no_wr", wcnt[0], 0);
    chk("rst_idle", bfirst[0], -1);

    // 8x8 random, three sweeps with bank swap
    fill(2, 2, 0);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 64; i++) mem[2][!rsel[2]][i] = 32'hDEAD_BEEF;
      sweep(2, 0, 0);
      check_sweep(2, "rnd");
      rsel[2] = !rsel[2];
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
